vm1_tve_host: RTL and testbench
===============================

Name: vm1_tve_host

Overview:
- CPU-side bus initiator and interrupt front-end for the 1801VM1 VE1-style timer.
- Converts one internal-bus transaction into the single-clock register strobes the timer consumes: csr/cnt/lim read enables and csr/lim write enables.
- Runs the timer interrupt-acknowledge sequence: presents the vector to the CPU and pulses the timer ack.
- Sits between the CPU bus controller and the timer instance, on the same clock.

Parameters:
- BASE_ADDR, 16'o177706, address of the limit register. Counter is at BASE+2, CSR at BASE+4.
- VECTOR, 16'o000270, interrupt vector returned on acknowledge.

Ports:
- tbh_clk  in  1  system clock, shared with the timer.
- tbh_reset  in  1  reset, synchronous, active-high.
- tbh_req  in  1  CPU bus request, level, held until tbh_ack.
- tbh_wr  in  1  1 = write, 0 = read.
- tbh_byte  in  1  byte access; the byte lane is selected by tbh_addr[0].
- tbh_addr  in  16  byte address.
- tbh_wdata  in  16  write data; a byte write carries its data on the addressed lane.
- tbh_rdata  out  16  read data, valid while tbh_ack is high.
- tbh_ack  out  1  transaction done, one-cycle pulse.
- tbh_sel  out  1  combinational: tbh_req is high and the address hits the 3-word window.
- tbh_virq  out  1  interrupt request to the CPU.
- tbh_iack  in  1  CPU interrupt-acknowledge pulse.
- tbh_ivec  out  16  vector, valid while tbh_ivld is high.
- tbh_ivld  out  1  vector-valid pulse.
- tve_din  out  16  data to the timer.
- tve_dout  in  16  OR-bus data from the timer.
- tve_csr_oe, tve_cnt_oe, tve_lim_oe  out  1 each  read enables.
- tve_csr_wr, tve_lim_wr  out  1 each  write enables.
- tve_irq  in  1  timer interrupt request.
- tve_ack  out  1  timer interrupt acknowledge.

Behaviour:
- Reset: synchronous to tbh_clk.
  - FSM goes to IDLE; all outputs are 0.
  - Any transaction in progress is aborted with no strobe and no ack.
  - Reset has priority over every other event.
- Address decode:
  - The word index is tbh_addr[15:1] minus BASE_ADDR[15:1]: 0 = LIM, 1 = CNT, 2 = CSR.
  - Any other index is not selected: no ack, FSM stays in IDLE (the CPU bus controller times out).
- FSM states: IDLE, SETUP, RD, MRD, MWR, WR, ACK, IVEC.
- IDLE:
  - tbh_iack high → IVEC. Interrupt acknowledge wins over a simultaneous request.
  - Else a selected tbh_req → SETUP. Address, wr, byte and wdata are latched at this point.
- SETUP, one cycle. Branches:
  - Read → RD.
  - Word write to LIM or CSR → WR.
  - Byte write to LIM → MRD.
  - Byte write to CSR, low byte (addr[0] = 0) → WR. High byte → ACK with no strobe; CSR bits 15:8 are read-only.
  - Any write to CNT → ACK with no strobe; CNT is read-only.
- RD:
  - Exactly one oe strobe is high for one cycle.
  - tve_dout is captured into tbh_rdata on the same edge.
  - → ACK. Read latency is 4 cycles from the IDLE sample of tbh_req to tbh_ack.
- MRD:
  - tve_lim_oe for one cycle; the limit is captured.
  - → MWR, which drives tve_din = captured limit with the addressed byte replaced from tbh_wdata.
  - → WR.
- WR:
  - The write strobe is high for one cycle.
  - tve_din holds the merged or word data during SETUP/MWR and WR.
  - A CSR write also reloads the timer counter from the limit (timer-side behaviour, no extra action here).
  - → ACK.
- ACK:
  - tbh_ack is high for one cycle; tbh_rdata is valid (0 for writes).
  - → IDLE.
  - tbh_req must be low or a new request on the next cycle. A held req is re-decoded as a new transaction.
- Strobes:
  - Never more than one tve_* strobe is high in a cycle.
  - tve_din is 0 outside write states.
- Interrupts:
  - tbh_virq = tve_irq & (state != IVEC), registered with a 1-cycle delay.
  - IVEC, one cycle: tbh_ivld = 1, tbh_ivec = VECTOR, tve_ack = 1 → IDLE.
  - tbh_iack while tve_irq is already 0 (spurious): IVEC still runs; the vector is returned and the ack is harmless.
  - tbh_iack arriving outside IDLE is latched into a pending flag and serviced on the next IDLE. Only one pending flag exists.

Test Plan:
- Word write 16'o001000 to 177706, then read 177706 → one tve_lim_wr pulse with tve_din = 16'o001000; read ack at cycle 4 with tbh_rdata = 16'o001000.
- Byte write 8'o377 to 177707 with limit = 16'o000012 → tve_lim_oe pulse, then tve_lim_wr with tve_din = 16'o177412; exactly one ack.
- Write to 177710, and byte write to 177713 → tbh_ack pulses with no tve_* strobe.
- Read of 177714 → tbh_sel = 0, no strobe, no ack, FSM stays in IDLE.
- tve_irq = 1, then tbh_iack together with tbh_req → IVEC first: tbh_ivec = 16'o000270, tve_ack pulses once, tbh_virq drops; the request is then served.
- Assert tbh_reset during MRD → next cycle all outputs 0, no tve_lim_wr ever issued, FSM in IDLE.

Source files
------------

// File: rtl/vm1_tve_host.sv
// CPU-side bus initiator and interrupt front-end for the 1801VM1 VE1-style timer:
// turns one bus transaction into single-cycle timer strobes and runs the vector handshake.
module vm1_tve_host #(
  parameter logic [15:0] BASE_ADDR = 16'o177706,
  parameter logic [15:0] VECTOR    = 16'o000270
) (
  input  logic        tbh_clk,
  input  logic        tbh_reset,
  input  logic        tbh_req,
  input  logic        tbh_wr,
  input  logic        tbh_byte,
  input  logic [15:0] tbh_addr,
  input  logic [15:0] tbh_wdata,
  output logic [15:0] tbh_rdata,
  output logic        tbh_ack,
  output logic        tbh_sel,
  output logic        tbh_virq,
  input  logic        tbh_iack,
  output logic [15:0] tbh_ivec,
  output logic        tbh_ivld,
  output logic [15:0] tve_din,
  input  logic [15:0] tve_dout,
  output logic        tve_csr_oe,
  output logic        tve_cnt_oe,
  output logic        tve_lim_oe,
  output logic        tve_csr_wr,
  output logic        tve_lim_wr,
  input  logic        tve_irq,
  output logic        tve_ack
);

  typedef enum logic [2:0] {IDLE, SETUP, RD, MRD, MWR, WR, ACK, IVEC} state_t;

  localparam logic [1:0] IDX_LIM = 2'd0;
  localparam logic [1:0] IDX_CNT = 2'd1;
  localparam logic [1:0] IDX_CSR = 2'd2;

  state_t      state, state_nxt;
  logic [14:0] idx_raw;
  logic [1:0]  idx_q;
  logic        wr_q, byte_q, lane_q;
  logic [15:0] din_q, rdata_q;
  logic        iack_pend, virq_q;

  // Word offset from the limit register; anything past CSR (or below LIM, via wrap) misses.
  assign idx_raw = tbh_addr[15:1] - BASE_ADDR[15:1];
  assign tbh_sel = tbh_req & (idx_raw < 15'd3);

  always_ff @(posedge tbh_clk) begin
    if (tbh_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (tbh_iack || iack_pend) state_nxt = IVEC;
        else if (tbh_sel)          state_nxt = SETUP;
      end
      SETUP: begin
        if (!wr_q)                  state_nxt = RD;
        else if (idx_q == IDX_CNT)  state_nxt = ACK;
        else if (idx_q == IDX_LIM)  state_nxt = byte_q ? MRD : WR;
        else                        state_nxt = (byte_q && lane_q) ? ACK : WR;
      end
      RD:      state_nxt = ACK;
      MRD:     state_nxt = MWR;
      MWR:     state_nxt = WR;
      WR:      state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      IVEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are pure state decodes, so at most one is ever high and all are 0 in IDLE.
  assign tve_lim_oe = ((state == RD) && (idx_q == IDX_LIM)) || (state == MRD);
  assign tve_cnt_oe = (state == RD) && (idx_q == IDX_CNT);
  assign tve_csr_oe = (state == RD) && (idx_q == IDX_CSR);
  assign tve_lim_wr = (state == WR) && (idx_q == IDX_LIM);
  assign tve_csr_wr = (state == WR) && (idx_q == IDX_CSR);
  assign tve_din    = (((state == SETUP) && wr_q) || (state == MWR) || (state == WR)) ? din_q : '0;
  assign tbh_ack    = (state == ACK);
  assign tbh_rdata  = tbh_ack ? rdata_q : '0;
  assign tbh_ivld   = (state == IVEC);
  assign tbh_ivec   = tbh_ivld ? VECTOR : '0;
  assign tve_ack    = tbh_ivld;
  assign tbh_virq   = virq_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge tbh_clk) begin
    if (tbh_reset) begin
      idx_q     <= IDX_LIM;
      wr_q      <= 1'b0;
      byte_q    <= 1'b0;
      lane_q    <= 1'b0;
      din_q     <= '0;
      rdata_q   <= '0;
      iack_pend <= 1'b0;
      virq_q    <= 1'b0;
    end else begin
      virq_q <= tve_irq & (state != IVEC);

      // IDLE always services a pending acknowledge, so the flag only needs to be set elsewhere.
      if (state == IDLE)  iack_pend <= 1'b0;
      else if (tbh_iack)  iack_pend <= 1'b1;

      if ((state == IDLE) && (state_nxt == SETUP)) begin
        idx_q   <= idx_raw[1:0];
        wr_q    <= tbh_wr;
        byte_q  <= tbh_byte;
        lane_q  <= tbh_addr[0];
        din_q   <= tbh_wdata;
        rdata_q <= '0;
      end

      if (state == RD) rdata_q <= tve_dout;

      // Byte write to LIM: keep the addressed lane from the CPU, the other from the timer.
      if (state == MRD)
        din_q <= lane_q ? {din_q[15:8], tve_dout[7:0]} : {tve_dout[15:8], din_q[7:0]};
    end
  end

endmodule

// File: tb/tb_vm1_tve_host.sv
// Randomized self-checking bench for vm1_tve_host: a stub timer on the strobes plus a
// transaction-level register model that predicts latency, strobes, write data and read data.
module tb_vm1_tve_host;

  localparam logic [15:0] BASE = 16'o177706;
  localparam logic [15:0] VEC  = 16'o000270;

  logic        tbh_clk = 1'b0;
  logic        tbh_reset = 1'b1;
  logic        tbh_req = 1'b0, tbh_wr = 1'b0, tbh_byte = 1'b0, tbh_iack = 1'b0;
  logic [15:0] tbh_addr = '0, tbh_wdata = '0;
  logic [15:0] tbh_rdata, tbh_ivec, tve_din, tve_dout;
  logic        tbh_ack, tbh_sel, tbh_virq, tbh_ivld;
  logic        tve_csr_oe, tve_cnt_oe, tve_lim_oe, tve_csr_wr, tve_lim_wr, tve_ack;
  logic        tve_irq = 1'b0;

  vm1_tve_host #(.BASE_ADDR(BASE), .VECTOR(VEC)) dut (
    .tbh_clk(tbh_clk), .tbh_reset(tbh_reset), .tbh_req(tbh_req), .tbh_wr(tbh_wr),
    .tbh_byte(tbh_byte), .tbh_addr(tbh_addr), .tbh_wdata(tbh_wdata), .tbh_rdata(tbh_rdata),
    .tbh_ack(tbh_ack), .tbh_sel(tbh_sel), .tbh_virq(tbh_virq), .tbh_iack(tbh_iack),
    .tbh_ivec(tbh_ivec), .tbh_ivld(tbh_ivld), .tve_din(tve_din), .tve_dout(tve_dout),
    .tve_csr_oe(tve_csr_oe), .tve_cnt_oe(tve_cnt_oe), .tve_lim_oe(tve_lim_oe),
    .tve_csr_wr(tve_csr_wr), .tve_lim_wr(tve_lim_wr), .tve_irq(tve_irq), .tve_ack(tve_ack)
  );

  always #5 tbh_clk = ~tbh_clk;

  // Stub timer: LIM and CNT are 16 bits, CSR keeps only its writable low byte.
  logic [15:0] stub_lim = '0;
  logic [15:0] stub_cnt = 16'o000123;
  logic [7:0]  stub_csr = '0;
  always @(posedge tbh_clk) begin
    if (tve_lim_wr) stub_lim <= tve_din;
    if (tve_csr_wr) begin
      stub_csr <= tve_din[7:0];
      stub_cnt <= stub_lim;
    end
  end
  assign tve_dout = ({16{tve_lim_oe}} & stub_lim) | ({16{tve_cnt_oe}} & stub_cnt) |
                    ({16{tve_csr_oe}} & {8'h00, stub_csr});

  // Running totals of every strobe; tasks take deltas, so only this block writes them.
  int tot_lim_oe = 0, tot_cnt_oe = 0, tot_csr_oe = 0, tot_lim_wr = 0, tot_csr_wr = 0;
  int tot_tack = 0, tot_ack = 0, tot_multi = 0;
  logic [15:0] last_lim_din = '0, last_csr_din = '0;
  always @(negedge tbh_clk) begin
    tot_lim_oe += int'(tve_lim_oe);
    tot_cnt_oe += int'(tve_cnt_oe);
    tot_csr_oe += int'(tve_csr_oe);
    tot_lim_wr += int'(tve_lim_wr);
    tot_csr_wr += int'(tve_csr_wr);
    tot_tack   += int'(tve_ack);
    tot_ack    += int'(tbh_ack);
    if ((int'(tve_lim_oe) + int'(tve_cnt_oe) + int'(tve_csr_oe) + int'(tve_lim_wr) +
         int'(tve_csr_wr) + int'(tve_ack)) > 1) tot_multi++;
    if (tve_lim_wr) last_lim_din = tve_din;
    if (tve_csr_wr) last_csr_din = tve_din;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Register model of the timer as the CPU sees it.
  logic [15:0] m_lim = '0, m_cnt = 16'o000123;
  logic [7:0]  m_csr = '0;

  // Expectation for the transaction in flight.
  logic        e_sel, e_rd;
  int          e_lat, e_lim_oe, e_cnt_oe, e_csr_oe, e_lim_wr, e_csr_wr, e_tack;
  logic [15:0] e_rdata, e_din;
  logic [15:0] n_lim, n_cnt;
  logic [7:0]  n_csr;
  int s_lim_oe, s_cnt_oe, s_csr_oe, s_lim_wr, s_csr_wr, s_tack, s_ack;

  task automatic drive_req(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    int idx;
    idx = int'(a[15:1]) - int'(BASE[15:1]);
    e_sel = (idx >= 0) && (idx <= 2);
    e_rd = !w;
    e_lim_oe = 0; e_cnt_oe = 0; e_csr_oe = 0; e_lim_wr = 0; e_csr_wr = 0; e_tack = 0;
    e_rdata = '0; e_din = '0; e_lat = 0;
    n_lim = m_lim; n_cnt = m_cnt; n_csr = m_csr;
    if (e_sel) begin
      if (!w) begin
        e_lat = 4;
        if (idx == 0)      begin e_lim_oe = 1; e_rdata = m_lim; end
        else if (idx == 1) begin e_cnt_oe = 1; e_rdata = m_cnt; end
        else               begin e_csr_oe = 1; e_rdata = {8'h00, m_csr}; end
      end else if (idx == 1 || (idx == 2 && b && a[0])) begin
        e_lat = 3;
      end else if (idx == 2) begin
        e_lat = 4; e_csr_wr = 1; e_din = d;
        n_csr = d[7:0]; n_cnt = m_lim;
      end else if (!b) begin
        e_lat = 4; e_lim_wr = 1; e_din = d; n_lim = d;
      end else begin
        e_lat = 6; e_lim_oe = 1; e_lim_wr = 1;
        e_din = a[0] ? ((d & 16'hFF00) | (m_lim & 16'h00FF)) : ((m_lim & 16'hFF00) | (d & 16'h00FF));
        n_lim = e_din;
      end
    end
    s_lim_oe = tot_lim_oe; s_cnt_oe = tot_cnt_oe; s_csr_oe = tot_csr_oe;
    s_lim_wr = tot_lim_wr; s_csr_wr = tot_csr_wr; s_tack = tot_tack; s_ack = tot_ack;
    tbh_req = 1'b1; tbh_wr = w; tbh_byte = b; tbh_addr = a; tbh_wdata = d;
    #1;
    check("sel", tbh_sel, e_sel);
  endtask

  // pre = clock edges already spent since the IDLE cycle that sampled the request.
  task automatic finish_req(input int pre);
    int n;
    logic got;
    logic [15:0] rd;
    if (!e_sel) begin
      repeat (8) @(posedge tbh_clk);
      #1;
      check("unsel_ack_n", tot_ack - s_ack, 0);
      check("unsel_strobes", (tot_lim_oe - s_lim_oe) + (tot_cnt_oe - s_cnt_oe) + (tot_csr_oe - s_csr_oe) +
            (tot_lim_wr - s_lim_wr) + (tot_csr_wr - s_csr_wr), 0);
      tbh_req = 1'b0;
      return;
    end
    n = pre; got = 1'b0; rd = '0;
    while (!got && n < 12) begin
      @(posedge tbh_clk);
      #1;
      n++;
      if (tbh_ack) begin got = 1'b1; rd = tbh_rdata; end
    end
    check("latency", got ? n + 1 : 99, e_lat);
    check(e_rd ? "rdata" : "wr_rdata", rd, e_rdata);
    tbh_req = 1'b0;
    @(posedge tbh_clk);
    #1;
    check("ack_pulse", tbh_ack, 0);
    check("ack_n", tot_ack - s_ack, 1);
    check("lim_oe_n", tot_lim_oe - s_lim_oe, e_lim_oe);
    check("cnt_oe_n", tot_cnt_oe - s_cnt_oe, e_cnt_oe);
    check("csr_oe_n", tot_csr_oe - s_csr_oe, e_csr_oe);
    check("lim_wr_n", tot_lim_wr - s_lim_wr, e_lim_wr);
    check("csr_wr_n", tot_csr_wr - s_csr_wr, e_csr_wr);
    check("tve_ack_n", tot_tack - s_tack, e_tack);
    if (e_lim_wr != 0) check("lim_din", last_lim_din, e_din);
    if (e_csr_wr != 0) check("csr_din_lo", last_csr_din[7:0], e_din[7:0]);
    m_lim = n_lim; m_cnt = n_cnt; m_csr = n_csr;
  endtask

  task automatic txn(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    drive_req(w, b, a, d);
    finish_req(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge tbh_clk);
    #1;
    check("rst_data", {tbh_rdata, tve_din}, 0);
    check("rst_ctl", {tbh_ivec, tbh_ack, tbh_sel, tbh_virq, tbh_ivld, tve_csr_oe, tve_cnt_oe,
                      tve_lim_oe, tve_csr_wr, tve_lim_wr, tve_ack}, 0);
    tbh_reset = 1'b0;
    @(posedge tbh_clk);
    #1;

    // Word write then read of LIM.
    txn(1'b1, 1'b0, 16'o177706, 16'o001000);
    txn(1'b0, 1'b0, 16'o177706, 16'o000000);
    // Byte write of the high LIM lane merges with the current limit.
    txn(1'b1, 1'b0, 16'o177706, 16'o000012);
    txn(1'b1, 1'b1, 16'o177707, 16'o177400);
    txn(1'b0, 1'b0, 16'o177706, 16'o000000);
    // Read-only targets: CNT write and CSR high-byte write.
    txn(1'b1, 1'b0, 16'o177710, 16'o123456);
    txn(1'b1, 1'b1, 16'o177713, 16'o177400);
    // Outside the window.
    txn(1'b0, 1'b0, 16'o177714, 16'o000000);

    // Interrupt acknowledge beats a simultaneous request.
    tve_irq = 1'b1;
    repeat (2) @(posedge tbh_clk);
    #1;
    check("virq_up", tbh_virq, 1);
    tbh_iack = 1'b1;
    drive_req(1'b0, 1'b0, 16'o177706, 16'o000000);
    e_tack = 1;
    @(posedge tbh_clk);
    #1;
    check("ivld", tbh_ivld, 1);
    check("ivec", tbh_ivec, VEC);
    check("tve_ack", tve_ack, 1);
    tbh_iack = 1'b0;
    @(posedge tbh_clk);
    #1;
    check("virq_masked", tbh_virq, 0);
    check("ivld_pulse", tbh_ivld, 0);
    tve_irq = 1'b0;
    finish_req(0);

    // Acknowledge during a transaction is held until the next IDLE.
    drive_req(1'b0, 1'b0, 16'o177710, 16'o000000);
    @(posedge tbh_clk);
    #1;
    tbh_iack = 1'b1;
    @(posedge tbh_clk);
    #1;
    tbh_iack = 1'b0;
    finish_req(2);
    @(posedge tbh_clk);
    #1;
    check("pend_ivld", tbh_ivld, 1);
    check("pend_ivec", tbh_ivec, VEC);
    @(posedge tbh_clk);
    #1;
    check("pend_once", tbh_ivld, 0);

    // Reset in the middle of a byte read-modify-write.
    drive_req(1'b1, 1'b1, 16'o177706, 16'o000077);
    @(posedge tbh_clk);
    #1;
    @(posedge tbh_clk);
    #1;
    check("mrd_lim_oe", tve_lim_oe, 1);
    tbh_reset = 1'b1;
    tbh_req = 1'b0;
    @(posedge tbh_clk);
    #1;
    check("rst_mid_data", {tbh_rdata, tve_din}, 0);
    check("rst_mid_ctl", {tbh_ivec, tbh_ack, tbh_sel, tbh_virq, tbh_ivld, tve_csr_oe, tve_cnt_oe,
                          tve_lim_oe, tve_csr_wr, tve_lim_wr, tve_ack}, 0);
    tbh_reset = 1'b0;
    repeat (6) @(posedge tbh_clk);
    #1;
    check("rst_no_lim_wr", tot_lim_wr - s_lim_wr, 0);
    check("rst_no_ack", tot_ack - s_ack, 0);
    txn(1'b0, 1'b0, 16'o177706, 16'o000000);

    // Random traffic over the window plus a few misses.
    for (int i = 0; i < 60; i++) begin
      int sel_kind;
      logic w, b;
      logic [15:0] a;
      sel_kind = int'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      if (sel_kind < 6)       a = BASE + 16'(2 * (sel_kind % 3)) + (b ? 16'($urandom_range(0, 1)) : 16'd0);
      else if (sel_kind == 6) a = BASE - 16'd2;
      else                    a = 16'($urandom_range(0, 16'o177000));
      txn(w, b, a, 16'($urandom));
    end

    check("one_strobe_max", tot_multi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
